// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit for the execute stage.
// Pipelined multiply, radix-2 restoring divide, start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(MUL_LAT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]  mcnt_q, mcnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] pipe_q [MUL_LAT];
  logic [2*W-1:0] pipe_d [MUL_LAT];

  logic           sgn;
  logic [2*W-1:0] ax, bx;
  logic [W-1:0]   am_in, bm;
  logic [W+1:0]   diff;

  always_comb begin
    sgn   = ~op_q[0];
    ax    = {{W{sgn & a_q[W-1]}}, a_q};
    bx    = {{W{sgn & b_q[W-1]}}, b_q};
    bm    = (sgn && b_q[W-1]) ? -b_q : b_q;
    am_in = (!op[0] && a[W-1]) ? -a : a;
    // trial subtraction of the shifted partial remainder
    diff  = {1'b0, rem_q, quo_q[W-1]} - {2'b0, bm};
  end

  // operands are frozen while busy, so the pipe only retimes the product
  always_comb begin
    pipe_d[0] = ax * bx;
    for (int i = 1; i < MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cancel) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          rem_d   = '0;
          quo_d   = am_in;
          cnt_d   = CW'(W);
          mcnt_d  = MW'(MUL_LAT);
          busy_d  = 1'b1;
          state_d = op[1] ? S_DIV : S_MUL;
        end
        S_MUL: begin
          mcnt_d = mcnt_q - MW'(1);
          if (mcnt_q == MW'(1)) state_d = S_FIN;
        end
        S_DIV: begin
          if (!diff[W+1]) rem_d = diff[W-1:0];
          else rem_d = {rem_q[W-2:0], quo_q[W-1]};
          quo_d = {quo_q[W-2:0], ~diff[W+1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          if (b_q == '0) begin
            rem_d = a_q;
            quo_d = '1;
          end else if (sgn) begin
            if (a_q[W-1] ^ b_q[W-1]) quo_d = -quo_q;
            if (a_q[W-1]) rem_d = -rem_q;
          end
          state_d = S_FIN;
        end
        S_FIN: begin
          hi_d    = op_q[1] ? rem_q : pipe_q[MUL_LAT-1][2*W-1:W];
          lo_d    = op_q[1] ? quo_q : pipe_q[MUL_LAT-1][W-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      mcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: 32-bit/lat-2 and 8-bit/lat-1 instances.
// 8-bit expectations come from a language-operator reference model.
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        st32, cn32, bz32, dn32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        st8, cn8, bz8, dn8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  bit          sel;
  logic        vbusy, vdone;
  logic [31:0] vhi, vlo;
  logic [31:0] last_h, last_l;
  int          n_cmp = 0;
  int          n_err = 0;

  alu_muldiv #(.WIDTH(32), .MUL_LAT(2)) u32 (
    .clk(clk), .rst(rst), .start(st32), .op(op32),
    .a(a32), .b(b32), .cancel(cn32),
    .busy(bz32), .done(dn32), .hi(hi32), .lo(lo32)
  );

  alu_muldiv #(.WIDTH(8), .MUL_LAT(1)) u8 (
    .clk(clk), .rst(rst), .start(st8), .op(op8),
    .a(a8), .b(b8), .cancel(cn8),
    .busy(bz8), .done(dn8), .hi(hi8), .lo(lo8)
  );

  assign vbusy = sel ? bz8 : bz32;
  assign vdone = sel ? dn8 : dn32;
  assign vhi   = sel ? {24'b0, hi8} : hi32;
  assign vlo   = sel ? {24'b0, lo8} : lo32;

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(bit w8, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    sel = w8;
    if (w8) begin
      st8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      st32 = 1'b1; op32 = o; a32 = x; b32 = y;
    end
  endtask

  task automatic idle_in();
    st8  = 1'b0;
    st32 = 1'b0;
    op8  = 2'($urandom);
    op32 = 2'($urandom);
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    a32  = $urandom;
    b32  = $urandom;
  endtask

  function automatic int lat(bit w8, logic [1:0] o);
    if (o[1]) return w8 ? 10 : 34;
    return w8 ? 2 : 3;
  endfunction

  function automatic logic [15:0] ref8(logic [1:0] o, logic [7:0] x,
                                       logic [7:0] y);
    logic [15:0] p;
    logic signed [15:0] sx, sy;
    sx = $signed({{8{x[7]}}, x});
    sy = $signed({{8{y[7]}}, y});
    p  = '0;
    if (o == 2'd0) p = 16'(sx * sy);
    else if (o == 2'd1) p = {8'b0, x} * {8'b0, y};
    else if (y == 8'h00) p = {x, 8'hFF};
    else if (o == 2'd2 && x == 8'h80 && y == 8'hFF) p = 16'h0080;
    else if (o == 2'd2) p = {8'(sx % sy), 8'(sx / sy)};
    else p = {x % y, x / y};
    return p;
  endfunction

  task automatic wait_res(bit w8, logic [1:0] o, int n0,
                          logic [31:0] eh, logic [31:0] el);
    string t;
    int n;
    t = $sformatf("w%0d op%0d", w8 ? 8 : 32, o);
    n = n0;
    while (!vdone && n < 100) begin
      step();
      n++;
    end
    check({t, " lat"}, 64'(n), 64'(lat(w8, o)));
    check({t, " busy@done"}, 64'(vbusy), 64'd0);
    check({t, " hi"}, 64'(vhi), 64'(eh));
    check({t, " lo"}, 64'(vlo), 64'(el));
    last_h = eh;
    last_l = el;
  endtask

  task automatic run(bit w8, logic [1:0] o, logic [31:0] x, logic [31:0] y,
                     logic [31:0] eh, logic [31:0] el);
    go(w8, o, x, y);
    step();
    idle_in();
    check("busy@accept", 64'(vbusy), 64'd1);
    wait_res(w8, o, 0, eh, el);
    step();
    check("done pulse", 64'(vdone), 64'd0);
  endtask

  task automatic run8(logic [1:0] o, logic [7:0] x, logic [7:0] y);
    logic [15:0] p;
    p = ref8(o, x, y);
    run(1'b1, o, {24'b0, x}, {24'b0, y}, {24'b0, p[15:8]}, {24'b0, p[7:0]});
  endtask

  task automatic cancel_test(bit w8, logic [31:0] x, logic [31:0] y,
                             logic [31:0] eh, logic [31:0] el);
    logic [31:0] ph, pl;
    ph = last_h;
    pl = last_l;
    go(w8, 2'b10, 32'h0000_0064, 32'h0000_0007);
    step();
    idle_in();
    step(9);
    if (w8) cn8 = 1'b1; else cn32 = 1'b1;
    step();
    cn8  = 1'b0;
    cn32 = 1'b0;
    check("cancel busy", 64'(vbusy), 64'd0);
    check("cancel done", 64'(vdone), 64'd0);
    check("cancel hi", 64'(vhi), 64'(ph));
    check("cancel lo", 64'(vlo), 64'(pl));
    run(w8, 2'b01, x, y, eh, el);
  endtask

  task automatic busy_test(bit w8);
    int dn;
    go(w8, 2'b00, 32'd3, 32'd4);
    step();
    go(w8, 2'b10, 32'd100, 32'd7);
    step();
    idle_in();
    wait_res(w8, 2'b00, 1, 32'd0, 32'd12);
    go(w8, 2'b01, 32'd5, 32'd6);
    step();
    idle_in();
    check("b2b accept", 64'(vbusy), 64'd1);
    wait_res(w8, 2'b01, 0, 32'd0, 32'd30);
    dn = 0;
    repeat (40) begin
      step();
      if (vdone) dn++;
    end
    check("stray done", 64'(dn), 64'd0);
  endtask

  logic [17:0] vec [9];

  initial begin
    vec = '{{2'd0, 8'hFE, 8'h03}, {2'd1, 8'hFF, 8'hFF},
            {2'd2, 8'hF9, 8'h02}, {2'd3, 8'h07, 8'h02},
            {2'd2, 8'h80, 8'hFF}, {2'd3, 8'h07, 8'h00},
            {2'd2, 8'hF9, 8'h00}, {2'd0, 8'h80, 8'h80},
            {2'd2, 8'h7F, 8'h81}};
    rst = 1'b1;
    cn8 = 1'b0;
    cn32 = 1'b0;
    idle_in();
    step(2);
    check("rst busy", 64'(bz32), 64'd0);
    check("rst done", 64'(dn32), 64'd0);
    check("rst hi", 64'(hi32), 64'd0);
    check("rst lo", 64'(lo32), 64'd0);
    check("rst hilo8", 64'({bz8, dn8, hi8, lo8}), 64'd0);
    rst = 1'b0;
    step();

    run(1'b0, 2'b00, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run(1'b0, 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(1'b0, 2'b11, 32'h7, 32'h2, 32'h1, 32'h3);
    run(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run(1'b0, 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run(1'b0, 2'b11, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF);
    cancel_test(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

    go(1'b0, 2'b11, 32'h7, 32'h2);
    cn32 = 1'b1;
    step();
    idle_in();
    cn32 = 1'b0;
    check("start+cancel busy", 64'(bz32), 64'd0);
    busy_test(1'b0);

    foreach (vec[i]) run8(vec[i][17:16], vec[i][15:8], vec[i][7:0]);
    for (int i = 0; i < 8; i++)
      run8(2'($urandom), 8'($urandom), 8'($urandom));
    begin
      logic [15:0] p;
      p = ref8(2'b01, 8'h10, 8'h10);
      cancel_test(1'b1, 32'h10, 32'h10, {24'b0, p[15:8]}, {24'b0, p[7:0]});
    end
    busy_test(1'b1);

    st32 = 1'b1; op32 = 2'b10; a32 = 32'hFFFF_FF00; b32 = 32'h3;
    st8  = 1'b1; op8  = 2'b10; a8  = 8'hF0;         b8  = 8'h3;
    step();
    idle_in();
    step(4);
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", 64'(bz32), 64'd0);
    check("arst hi", 64'(hi32), 64'd0);
    check("arst lo", 64'(lo32), 64'd0);
    check("arst 8", 64'({bz8, dn8, hi8, lo8}), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post-rst done", 64'({dn32, dn8}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
